// File: rtl/gf3m_arith_unit.sv
// gf3m_arith_unit
// ---------------------------------------------------------------------------
// Sequential GF(3^M) arithmetic element that performs add, sub, multiply and
// cube. The modulus is the trinomial f(x) = x^M + x^K + 2, so x^M reduces to
// 2*x^K + 1. Multiplication is digit-serial: it consumes D trits of the
// multiplier per cycle, most significant digit first.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   operation request (sampled only when busy=0)
//   op     in   00 add, 01 sub (a-b), 10 mul (a*b), 11 cube (a^3, b ignored)
//   a, b   in   operands, 2 bits per trit, trit i at [2i+1:2i]
//   busy   out  high while a multi-cycle operation runs
//   done   out  one-cycle pulse, out is valid in that cycle
//   out    out  result, held until the next accepted start completes
//
// Handshake: a request is accepted on a rising edge where start=1 and
// busy=0, which includes the FIN cycle (done=1), so back-to-back issue is
// possible. a, b and op are captured on that edge and may change afterwards.
// A start while busy=1 is dropped, not queued. The result appears on out in
// the cycle where done=1 and stays there until the next FIN cycle.
// Trit code 11 on an input is read as 0; out only ever carries 00/01/10.
// ---------------------------------------------------------------------------
module gf3m_arith_unit #(
  parameter int M = 97,
  parameter int K = 12,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [2*M-1:0] a,
  input  logic [2*M-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [2*M-1:0] out
);

  localparam int N  = (M + D - 1) / D;        // multiply iterations
  localparam int P  = N * D;                  // multiplier width in trits after zero-extension
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // ADDSUB is part of the state set, but add/sub resolve in the accept
  // cycle and jump straight to FIN, so it is never entered.
  typedef enum logic [2:0] {
    S_IDLE, S_ADDSUB, S_MUL, S_CUBE1, S_CUBE2, S_FIN
  } state_e;

  // ---------------- trit / polynomial helpers ----------------
  function automatic logic [1:0] t_add(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] t_neg(input logic [1:0] x);
    return (x == 2'd1) ? 2'd2 : (x == 2'd2) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] t_mul(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    return (x == y) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [2*M-1:0] p_clean(input logic [2*M-1:0] p);
    logic [2*M-1:0] r;
    for (int i = 0; i < M; i++)
      r[2*i +: 2] = (p[2*i +: 2] == 2'b11) ? 2'b00 : p[2*i +: 2];
    return r;
  endfunction

  function automatic logic [2*M-1:0] p_add(input logic [2*M-1:0] p, input logic [2*M-1:0] q);
    logic [2*M-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = t_add(p[2*i +: 2], q[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [2*M-1:0] p_neg(input logic [2*M-1:0] p);
    logic [2*M-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = t_neg(p[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [2*M-1:0] p_scale(input logic [2*M-1:0] p, input logic [1:0] c);
    logic [2*M-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = t_mul(p[2*i +: 2], c);
    return r;
  endfunction

  // Multiply by x mod f: the trit shifted out at x^M comes back as
  // 2*top at x^K and top at x^0.
  function automatic logic [2*M-1:0] p_mulx(input logic [2*M-1:0] p);
    logic [2*M-1:0] r;
    logic [1:0]     top;
    top           = p[2*M-1 -: 2];
    r             = {p[2*M-3:0], 2'b00};
    r[2*K +: 2]   = t_add(r[2*K +: 2], t_neg(top));
    r[1:0]        = top;
    return r;
  endfunction

  // One digit-serial iteration: acc*x^D + sum_j dig_j * mc * x^j (mod f).
  function automatic logic [2*M-1:0] mul_step(input logic [2*M-1:0] acc,
                                               input logic [2*M-1:0] mc,
                                               input logic [2*D-1:0] dig);
    logic [2*M-1:0] r;
    logic [2*M-1:0] s;
    r = acc;
    for (int i = 0; i < D; i++) r = p_mulx(r);
    s = mc;
    for (int j = 0; j < D; j++) begin
      r = p_add(r, p_scale(s, dig[2*j +: 2]));
      s = p_mulx(s);
    end
    return r;
  endfunction

  // ---------------- state and datapath registers ----------------
  state_e         state_q, state_d;
  logic [2*M-1:0] acc_q, acc_d;        // running product
  logic [2*M-1:0] mcand_q, mcand_d;    // multiplicand (always a)
  logic [2*P-1:0] mplier_q, mplier_d;  // multiplier, top digit at the MSB end
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*M-1:0] out_q, out_d;

  logic [2*M-1:0] a_c, b_c, step;
  logic [2*P-1:0] a_ext, b_ext, step_ext;
  logic           last_iter;

  assign a_c       = p_clean(a);
  assign b_c       = p_clean(b);
  assign step      = mul_step(acc_q, mcand_q, mplier_q[2*P-1 -: 2*D]);
  assign last_iter = (cnt_q == CW'(N - 1));

  always_comb begin
    a_ext = '0;
    b_ext = '0;
    step_ext = '0;
    a_ext[2*M-1:0]    = a_c;
    b_ext[2*M-1:0]    = b_c;
    step_ext[2*M-1:0] = step;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (start) begin
          mcand_d = a_c;
          acc_d   = '0;
          cnt_d   = '0;
          case (op)
            2'b00: begin out_d = p_add(a_c, b_c);        state_d = S_FIN; end
            2'b01: begin out_d = p_add(a_c, p_neg(b_c)); state_d = S_FIN; end
            2'b10: begin mplier_d = b_ext;               state_d = S_MUL; end
            default: begin mplier_d = a_ext;             state_d = S_CUBE1; end
          endcase
        end
      end
      S_MUL, S_CUBE2: begin
        acc_d    = step;
        mplier_d = mplier_q << (2*D);
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          out_d   = step;
          state_d = S_FIN;
        end
      end
      S_CUBE1: begin
        acc_d    = step;
        mplier_d = mplier_q << (2*D);
        cnt_d    = cnt_q + 1'b1;
        // a^2 is done: it becomes the multiplier for the second pass (a^2 * a).
        if (last_iter) begin
          acc_d    = '0;
          mplier_d = step_ext;
          cnt_d    = '0;
          state_d  = S_CUBE2;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_CUBE1) || (state_q == S_CUBE2);
  assign done = (state_q == S_FIN);
  assign out  = out_q;

endmodule

// File: tb/tb_gf3m_arith_unit.sv
// Bench for gf3m_arith_unit: three instances (D=3, D=1, D=7) share operand
// and op inputs but have separate start lines. Expected results are computed
// from an integer polynomial model and queued per instance; a negedge monitor
// pops and compares on every done pulse.
module tb_gf3m_arith_unit;

  localparam int M = 97;
  localparam int K = 12;
  localparam int W = 2 * M;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   start_v = 3'b000;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy0, busy1, busy2, done0, done1, done2;
  logic [W-1:0] out0, out1, out2;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  int checks = 0;
  int errors = 0;
  int dv[3] = '{3, 1, 7};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  gf3m_arith_unit #(.M(M), .K(K), .D(3)) u_d3 (
    .clk(clk), .reset(reset), .start(start_v[0]), .op(op), .a(a), .b(b),
    .busy(busy0), .done(done0), .out(out0));
  gf3m_arith_unit #(.M(M), .K(K), .D(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .op(op), .a(a), .b(b),
    .busy(busy1), .done(done1), .out(out1));
  gf3m_arith_unit #(.M(M), .K(K), .D(7)) u_d7 (
    .clk(clk), .reset(reset), .start(start_v[2]), .op(op), .a(a), .b(b),
    .busy(busy2), .done(done2), .out(out2));

  function automatic logic done_of(input int i);
    return (i == 0) ? done0 : (i == 1) ? done1 : done2;
  endfunction
  function automatic logic busy_of(input int i);
    return (i == 0) ? busy0 : (i == 1) ? busy1 : busy2;
  endfunction
  function automatic logic [W-1:0] out_of(input int i);
    return (i == 0) ? out0 : (i == 1) ? out1 : out2;
  endfunction

  // ---------------- reference model ----------------
  function automatic int tv(input logic [W-1:0] x, input int i);
    logic [1:0] t;
    t = x[2*i +: 2];
    return (t == 2'b11) ? 0 : int'(t);
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int px[M];
    int py[M];
    int pr[2*M-1];
    int c;
    logic [W-1:0] r;
    for (int i = 0; i < M; i++) begin px[i] = tv(x, i); py[i] = tv(y, i); end
    for (int i = 0; i < 2*M-1; i++) pr[i] = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) pr[i+j] += px[i] * py[j];
    // x^d = x^(d-M) * (2x^K + 1), reduced from the top down
    for (int d = 2*M-2; d >= M; d--) begin
      c = pr[d] % 3;
      pr[d] = 0;
      pr[d-M+K] += 2 * c;
      pr[d-M]   += c;
    end
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(pr[i] % 3);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0] r;
    r = '0;
    case (o)
      2'b00: for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((tv(x, i) + tv(y, i)) % 3);
      2'b01: for (int i = 0; i < M; i++) r[2*i +: 2] = 2'((tv(x, i) - tv(y, i) + 3) % 3);
      2'b10: r = ref_mul(x, y);
      default: r = ref_mul(ref_mul(x, x), x);
    endcase
    return r;
  endfunction

  function automatic int lat_of(input int i, input logic [1:0] o);
    int n;
    n = (M + dv[i] - 1) / dv[i];
    if (o == 2'b10) return n + 1;
    if (o == 2'b11) return 2 * n + 1;
    return 1;
  endfunction

  function automatic logic [W-1:0] rnd_poly();
    logic [W-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic push_exp(input int i, input logic [W-1:0] e);
    if (i == 0) exp_q0.push_back(e);
    else if (i == 1) exp_q1.push_back(e);
    else exp_q2.push_back(e);
  endtask

  task automatic pop_exp(input int i, output bit ok, output logic [W-1:0] e);
    ok = 1'b0;
    e  = '0;
    if (i == 0 && exp_q0.size() > 0) begin ok = 1'b1; e = exp_q0.pop_front(); end
    if (i == 1 && exp_q1.size() > 0) begin ok = 1'b1; e = exp_q1.pop_front(); end
    if (i == 2 && exp_q2.size() > 0) begin ok = 1'b1; e = exp_q2.pop_front(); end
  endtask

  logic [W-1:0] prev_out[3];
  logic         prev_done[3] = '{1'b0, 1'b0, 1'b0};
  logic         rst_prev = 1'b1;

  always @(negedge clk) begin
    bit           ok;
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      if (!reset && done_of(i)) begin
        checks++;
        if (prev_done[i]) begin
          errors++;
          $display("FAIL done_width inst%0d: done high two cycles in a row, want 1-cycle pulse", i);
        end
        pop_exp(i, ok, e);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL unexpected_done inst%0d: out=%h with no expected result queued", i, out_of(i));
        end else if (out_of(i) !== e) begin
          errors++;
          $display("FAIL result inst%0d: got %h want %h", i, out_of(i), e);
        end
      end
      if (!reset && !rst_prev && !done_of(i)) begin
        checks++;
        if (out_of(i) !== prev_out[i]) begin
          errors++;
          $display("FAIL out_hold inst%0d: out changed to %h from %h outside done", i, out_of(i), prev_out[i]);
        end
      end
      prev_out[i]  = out_of(i);
      prev_done[i] = done_of(i);
    end
    rst_prev = reset;
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic issue(input int i, input logic [1:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] e);
    op = o;
    a  = x;
    b  = y;
    start_v[i] = 1'b1;
    push_exp(i, e);
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    a = rnd_poly();   // operands must not matter after acceptance
    b = rnd_poly();
  endtask

  // Waits for done; checks latency from the accept edge, busy cycles and busy=0 in the done cycle.
  task automatic wait_done(input int i, input int lat);
    int c;
    int bc;
    bit seen;
    c = 0; bc = 0; seen = 1'b0;
    while (!seen && c < lat + 20) begin
      @(negedge clk);
      c++;
      if (done_of(i)) seen = 1'b1;
      else begin
        if (busy_of(i)) bc++;
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!seen || c != lat) begin
      errors++;
      $display("FAIL latency inst%0d: done after %0d cycles (seen=%0b), want %0d", i, c, seen, lat);
    end
    checks++;
    if (bc != lat - 1) begin
      errors++;
      $display("FAIL busy_cycles inst%0d: got %0d want %0d", i, bc, lat - 1);
    end
    checks++;
    if (seen && busy_of(i)) begin
      errors++;
      $display("FAIL busy_in_done inst%0d: busy=1 during done cycle, want 0", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input int i, input logic [1:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] e);
    issue(i, o, x, y, e);
    wait_done(i, lat_of(i, o));
  endtask

  task automatic run_rand(input int i, input logic [1:0] o);
    logic [W-1:0] x;
    logic [W-1:0] y;
    x = rnd_poly();
    y = rnd_poly();
    run(i, o, x, y, ref_op(o, x, y));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] one;
    logic [W-1:0] x1, y1, x2, y2;
    int dcount;
    one = 1;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_of(i) !== '0 || busy_of(i) !== 1'b0 || done_of(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: out=%h busy=%b done=%b want 0/0/0",
                 i, out_of(i), busy_of(i), done_of(i));
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // directed cases on the D=3 instance
    run(0, 2'b00, one, W'(2), '0);
    run(0, 2'b01, '0, one, W'(2));
    run(0, 2'b00, W'(3), one, one);
    run(0, 2'b10, one << 192, W'(4), W'('h2000001));
    run(0, 2'b11, one << 66, '0, W'('h20000010));

    // start held high through a mul: the second request is taken only in FIN
    x1 = rnd_poly(); y1 = rnd_poly(); x2 = rnd_poly(); y2 = rnd_poly();
    op = 2'b10; a = x1; b = y1; start_v[0] = 1'b1;
    push_exp(0, ref_mul(x1, y1));
    @(posedge clk); #1;
    a = x2; b = y2;
    push_exp(0, ref_mul(x2, y2));
    wait_done(0, lat_of(0, 2'b10));
    start_v[0] = 1'b0;
    wait_done(0, lat_of(0, 2'b10));

    // random regression, all ops, D=3
    for (int n = 0; n < 1000; n++) run_rand(0, 2'($urandom_range(0, 3)));

    // multiply at D=1 and D=7 (D=7 zero-extends b to 98 trits)
    for (int n = 0; n < 60; n++) run_rand(1, 2'b10);
    for (int n = 0; n < 60; n++) run_rand(2, 2'b10);
    for (int n = 0; n < 10; n++) run_rand(2, 2'b11);
    for (int n = 0; n < 4; n++)  run_rand(1, 2'($urandom_range(0, 1)));

    // reset in cycle T+10 of a mul aborts it
    issue(0, 2'b10, rnd_poly(), rnd_poly(), '0);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out0 !== '0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_mul: out=%h busy=%b done=%b want 0/0/0", out0, busy0, done0);
    end
    exp_q0.delete();
    dcount = 0;
    repeat (50) begin
      @(negedge clk);
      if (done0) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      errors++;
      $display("FAIL no_done_after_reset: got %0d done pulses want 0", dcount);
    end

    checks++;
    if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
      errors++;
      $display("FAIL pending_results: %0d/%0d/%0d results never delivered, want 0",
               exp_q0.size(), exp_q1.size(), exp_q2.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
